// File: rtl/memory_sum_controller.sv
// Sequentially reads N_READ words from a registered-I/O single-port RAM, sums them
// (wrapping), writes the sum to address N_READ and pulses ready once.
`timescale 1ns/1ps
module memory_sum_controller #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int N_READ = 31
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] address,
    output logic              rden,
    output logic              wren,
    output logic              ready,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dataout
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_READ - 1);
    localparam logic [ADDR_W-1:0] WR_ADDR  = ADDR_W'(N_READ);

    typedef enum logic [3:0] {
        RD_ADDR,
        RD_W1,
        RD_W2,
        RD_W3,
        RD_LOAD,
        WR_SETUP,
        WR,
        WR_HOLD,
        DONE,
        HALT
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_index;
    logic [DATA_W-1:0]   r_acc;
    logic [ADDR_W-1:0]   r_address;
    logic                r_rden;
    logic                r_wren;
    logic                r_ready;
    logic [DATA_W-1:0]   r_dataout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RD_ADDR;
            r_index   <= '0;
            r_acc     <= '0;
            r_address <= '0;
            r_rden    <= 1'b0;
            r_wren    <= 1'b0;
            r_ready   <= 1'b0;
            r_dataout <= '0;
        end else begin
            case (r_state)
                RD_ADDR: begin
                    r_address <= r_index;
                    r_rden    <= 1'b1;
                    r_state   <= RD_W1;
                end
                // Three wait states cover the RAM's two-cycle read latency with a cycle of margin.
                RD_W1: r_state <= RD_W2;
                RD_W2: r_state <= RD_W3;
                RD_W3: r_state <= RD_LOAD;
                RD_LOAD: begin
                    r_acc  <= r_acc + datain;
                    r_rden <= 1'b0;
                    if (r_index == LAST_IDX) begin
                        r_state <= WR_SETUP;
                    end else begin
                        r_index <= r_index + 1'b1;
                        r_state <= RD_ADDR;
                    end
                end
                WR_SETUP: begin
                    r_address <= WR_ADDR;
                    r_dataout <= r_acc;
                    r_wren    <= 1'b0;
                    r_state   <= WR;
                end
                WR: begin
                    r_wren  <= 1'b1;
                    r_state <= WR_HOLD;
                end
                WR_HOLD: begin
                    r_wren  <= 1'b0;
                    r_state <= DONE;
                end
                DONE: begin
                    r_ready <= 1'b1;
                    r_state <= HALT;
                end
                HALT: begin
                    r_ready <= 1'b0;
                end
                default: r_state <= RD_ADDR;
            endcase
        end
    end

    assign address = r_address;
    assign rden    = r_rden;
    assign wren    = r_wren;
    assign ready   = r_ready;
    assign dataout = r_dataout;

endmodule

// File: tb/tb_memory_sum_controller.sv
// Bench for memory_sum_controller: registered-I/O RAM model, write scoreboard,
// protocol monitor and directed runs including resets mid-read and during the write.
`timescale 1ns/1ps
module tb_memory_sum_controller;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int NR = 31;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address;
    logic          rden, wren, ready;
    logic [DW-1:0] datain;
    logic [DW-1:0] dataout;

    always #5 clk = ~clk;

    memory_sum_controller #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR)) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .rden    (rden),
        .wren    (wren),
        .ready   (ready),
        .datain  (datain),
        .dataout (dataout)
    );

    // RAM model: address registered, then q registered (two-cycle read latency)
    logic [DW-1:0] mem [32];
    logic [DW-1:0] init_vals [32];
    logic          load_en = 1'b0;
    logic [AW-1:0] ram_addr_q = '0;

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_vals[i];
        end else if (wren) begin
            mem[address] <= dataout;
        end
        ram_addr_q <= address;
        datain     <= mem[ram_addr_q];
    end

    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t sb[$];
    wr_t exp_w;

    int            n_writes = 0;
    int            n_rden_rise = 0;
    int            run_len = 0;
    logic          rden_p = 1'b0;
    logic          wren_p = 1'b0;
    logic          reset_p = 1'b1;
    logic [AW-1:0] addr_p = '0;

    // Scoreboard pop on writes plus protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (wren === 1'b1) begin
            n_writes++;
            chk("rden_wren_overlap", {31'd0, rden}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                exp_w = sb.pop_front();
                chk("wr_addr", {27'd0, address}, {27'd0, exp_w.a});
                chk("wr_data", {16'd0, dataout}, {16'd0, exp_w.d});
            end
        end
        if (wren === 1'b1 && !wren_p)
            chk("addr_stable_before_wren", {27'd0, address}, {27'd0, addr_p});
        if (wren === 1'b0 && wren_p && !reset && !reset_p)
            chk("addr_held_at_wren_fall", {27'd0, address}, {27'd0, addr_p});
        if (rden === 1'b1 && !rden_p) n_rden_rise++;
        if (rden === 1'b0 && rden_p && !reset && !reset_p)
            chk("rden_width_ge4", {31'd0, (run_len >= 4)}, 32'd1);
        run_len = (rden === 1'b1) ? run_len + 1 : 0;
        rden_p  = (rden === 1'b1);
        wren_p  = (wren === 1'b1);
        reset_p = reset;
        addr_p  = address;
    end

    task automatic load(input int mode);
        for (int i = 0; i < 32; i++) begin
            case (mode)
                0:       init_vals[i] = DW'(i + 1);
                1:       init_vals[i] = 16'hFFFF;
                2:       init_vals[i] = 16'h0000;
                default: init_vals[i] = DW'($urandom);
            endcase
        end
        init_vals[31] = 16'h0000;
        load_en = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    function automatic logic [DW-1:0] sum_exp();
        logic [DW-1:0] s = '0;
        for (int i = 0; i < NR; i++) s = s + init_vals[i];
        return s;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_address"}, {27'd0, address}, 32'd0);
        chk({tag, "_rden"},    {31'd0, rden},    32'd0);
        chk({tag, "_wren"},    {31'd0, wren},    32'd0);
        chk({tag, "_ready"},   {31'd0, ready},   32'd0);
        chk({tag, "_dataout"}, {16'd0, dataout}, 32'd0);
    endtask

    // Releases reset (called #1 after a posedge) and runs to completion
    task automatic run_full(input string tag, input logic [DW-1:0] exp_sum);
        int cyc = 0;
        int w0, r0, bad;
        sb.push_back('{a: AW'(NR), d: exp_sum});
        w0 = n_writes;
        reset = 1'b0;
        while (cyc < 400 && ready !== 1'b1) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 32'd159);
        @(posedge clk); #1;
        chk({tag, "_ready_1cyc"}, {31'd0, ready}, 32'd0);
        r0 = n_rden_rise;
        repeat (20) @(posedge clk);
        #1;
        chk({tag, "_no_rden_after_done"}, n_rden_rise, r0);
        chk({tag, "_ready_stays_low"}, {31'd0, ready}, 32'd0);
        chk({tag, "_write_count"}, n_writes - w0, 32'd1);
        chk({tag, "_ram31"}, {16'd0, mem[31]}, {16'd0, exp_sum});
        bad = 0;
        for (int i = 0; i < NR; i++) if (mem[i] !== init_vals[i]) bad++;
        chk({tag, "_ram_unchanged"}, bad, 32'd0);
    endtask

    initial begin
        int cyc;
        int w0;
        logic [DW-1:0] e;

        // Incrementing pattern
        apply_reset();
        load(0);
        check_reset_vals("reset");
        run_full("inc", 16'h01F0);

        // All 0xFFFF: wraps
        apply_reset();
        load(1);
        run_full("ffff", 16'hFFE1);

        // All zero
        apply_reset();
        load(2);
        run_full("zero", 16'h0000);

        // Random contents
        apply_reset();
        load(3);
        run_full("rand", sum_exp());

        // Reset mid-read of address 10
        apply_reset();
        load(0);
        w0 = n_writes;
        reset = 1'b0;
        cyc = 0;
        while (cyc < 200 && !(address === AW'(10) && rden === 1'b1)) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("midrd_reached_addr10", {31'd0, (cyc < 200)}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("midrd");
        chk("midrd_no_write", n_writes - w0, 32'd0);
        run_full("midrd_rerun", 16'h01F0);

        // Reset while wren is high
        apply_reset();
        load(3);
        e = sum_exp();
        sb.push_back('{a: AW'(NR), d: e});
        reset = 1'b0;
        cyc = 0;
        while (cyc < 300 && wren !== 1'b1) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("wrabort_reached_wren", {31'd0, (cyc < 300)}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("wrabort_wren_drop", {31'd0, wren}, 32'd0);
        chk("wrabort_ready", {31'd0, ready}, 32'd0);
        chk("wrabort_address", {27'd0, address}, 32'd0);
        run_full("wrabort_rerun", e);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
